// File: rtl/trans_pkg.sv
// Shared types, fixed-point constants and arithmetic helpers for the
// transmission-estimation pipeline.
package trans_pkg;

  // Q1.16 transmission / normalised-intensity width (65536 = 1.0)
  localparam int unsigned Q_W        = 17;
  localparam int unsigned CHAN_W     = 8;
  // Reciprocal constant width: floor(2^24 / 1) needs 25 bits
  localparam int unsigned K_W        = 25;
  localparam int unsigned PROD_W     = CHAN_W + K_W;
  localparam int unsigned OMG_W      = 8;
  localparam int unsigned OMG_PROD_W = Q_W + OMG_W;
  localparam int unsigned FRAC_SH    = 8;

  localparam logic [Q_W-1:0] ONE_Q = 17'h1_0000;

  typedef logic [Q_W-1:0]    q_t;
  typedef logic [CHAN_W-1:0] chan_t;
  typedef logic [K_W-1:0]    k_t;

  // Pixel as it arrives on the bus: R in the top byte, B in the bottom byte
  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } bgr_t;

  // Reciprocal of the atmospheric light, scaled by 2^24
  function automatic k_t calc_k(input int unsigned atm);
    return K_W'(32'h0100_0000 / atm);
  endfunction

  // (I * K) >> 8, saturated to 1.0
  function automatic q_t normalise(input chan_t i, input k_t k);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] shr;
    prod = PROD_W'(i) * PROD_W'(k);
    shr  = prod >> FRAC_SH;
    if (shr > PROD_W'(ONE_Q)) begin
      return ONE_Q;
    end
    return Q_W'(shr);
  endfunction

  function automatic q_t min2(input q_t a, input q_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/trans_est_if.sv
// Pixel-in / transmission-out bus of the transmission-estimation stage.
interface trans_est_if;
  import trans_pkg::*;

  bgr_t input_pixel;
  logic input_is_valid;
  q_t   transmission;
  logic trans_valid;

  // Pixel source side
  modport master (
    output input_pixel,
    output input_is_valid,
    input  transmission,
    input  trans_valid
  );

  // Estimator side
  modport slave (
    input  input_pixel,
    input  input_is_valid,
    output transmission,
    output trans_valid
  );

endinterface

// File: rtl/dark_win_min.sv
// Causal 3x3 minimum over rows r-2..r and cols c-2..c of the per-pixel
// channel minimum. Owns the raster counters, two line buffers and the
// two-deep column history. One cycle from in_valid to out_valid.
module dark_win_min
  import trans_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  q_t   in_d,
  output logic out_valid,
  output q_t   out_dark
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  // Line buffers hold rows r-1 and r-2; never reset, masked by row_q
  q_t lb1_mem [IMG_WIDTH];
  q_t lb2_mem [IMG_WIDTH];

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  q_t               hist1_q, hist1_d;
  q_t               hist2_q, hist2_d;
  q_t               dark_q, dark_d;
  logic             valid_q, valid_d;

  q_t lb1_rd;
  q_t lb2_rd;
  q_t tap_up1;
  q_t tap_up2;
  q_t tap_l1;
  q_t tap_l2;
  q_t colmin;

  // Window taps, counter advance and history shift
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hist1_d = hist1_q;
    hist2_d = hist2_q;
    dark_d  = dark_q;
    valid_d = in_valid;

    lb1_rd  = lb1_mem[col_q];
    lb2_rd  = lb2_mem[col_q];

    // Rows above the frame top read as 1.0 so they never win the minimum
    tap_up1 = (row_q != '0)          ? lb1_rd : ONE_Q;
    tap_up2 = (row_q >  ROW_W'(1))   ? lb2_rd : ONE_Q;
    colmin  = min2(in_d, min2(tap_up1, tap_up2));

    // History left over from the previous row is ignored at the left edge
    tap_l1  = (col_q != '0)          ? hist1_q : ONE_Q;
    tap_l2  = (col_q >  COL_W'(1))   ? hist2_q : ONE_Q;

    if (in_valid) begin
      dark_d  = min2(colmin, min2(tap_l1, tap_l2));
      hist2_d = hist1_q;
      hist1_d = colmin;
      if (col_q == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Counter, history and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hist1_q <= ONE_Q;
      hist2_q <= ONE_Q;
      dark_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      dark_q  <= dark_d;
      valid_q <= valid_d;
    end
  end

  // Line-buffer shift: the row below slides up one line per accepted pixel
  always_ff @(posedge clk) begin
    if (rst && in_valid) begin
      lb2_mem[col_q] <= lb1_rd;
      lb1_mem[col_q] <= in_d;
    end
  end

  assign out_valid = valid_q;
  assign out_dark  = dark_q;

endmodule

// File: rtl/trans_est_top.sv
// Transmission estimation for dark-channel-prior dehazing:
// normalise by A -> channel min -> causal 3x3 min -> t = 1 - omega*dark.
// Four register stages, fixed latency, no backpressure.
// Optional build macro TRANS_T0_CLAMP_EN clamps t from below at T0_Q.
module trans_est_top
  import trans_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned ATM_R      = 255,
  parameter int unsigned ATM_G      = 255,
  parameter int unsigned ATM_B      = 255,
  parameter int unsigned OMEGA_Q    = 240,
  parameter int unsigned T0_Q       = 6554
) (
  input  logic        clk,
  input  logic        rst,
  trans_est_if.slave  bus
);

  localparam k_t K_R = calc_k(ATM_R);
  localparam k_t K_G = calc_k(ATM_G);
  localparam k_t K_B = calc_k(ATM_B);

  // Reject configurations that would divide by zero or overflow Q1.16
  if (ATM_R < 1 || ATM_R > 255 || ATM_G < 1 || ATM_G > 255 ||
      ATM_B < 1 || ATM_B > 255 || OMEGA_Q > 255 ||
      T0_Q > 65536 || IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_cfg
    $error("trans_est_top: parameter out of range");
  end

  // Stage 1: normalised channels
  q_t   n_r_q, n_r_d;
  q_t   n_g_q, n_g_d;
  q_t   n_b_q, n_b_d;
  logic v1_q, v1_d;

  // Stage 2: per-pixel channel minimum
  q_t   d_q, d_d;
  logic v2_q, v2_d;

  // Stage 3: windowed minimum (registered inside dark_win_min)
  q_t   dark;
  logic v3;

  // Stage 4: transmission
  q_t   trans_q, trans_d;
  logic tv_q, tv_d;

  logic [OMG_PROD_W-1:0] omg_prod;
  q_t                    omg_term;
  q_t                    t_raw;

  // Normalise each channel by its atmospheric light
  always_comb begin
    v1_d  = bus.input_is_valid;
    n_r_d = n_r_q;
    n_g_d = n_g_q;
    n_b_d = n_b_q;
    if (bus.input_is_valid) begin
      n_r_d = normalise(bus.input_pixel.r, K_R);
      n_g_d = normalise(bus.input_pixel.g, K_G);
      n_b_d = normalise(bus.input_pixel.b, K_B);
    end
  end

  // Minimum over the three normalised channels
  always_comb begin
    v2_d = v1_q;
    d_d  = d_q;
    if (v1_q) begin
      d_d = min2(n_r_q, min2(n_g_q, n_b_q));
    end
  end

  // Stage 1 and stage 2 registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      n_r_q <= '0;
      n_g_q <= '0;
      n_b_q <= '0;
      v1_q  <= 1'b0;
      d_q   <= '0;
      v2_q  <= 1'b0;
    end else begin
      n_r_q <= n_r_d;
      n_g_q <= n_g_d;
      n_b_q <= n_b_d;
      v1_q  <= v1_d;
      d_q   <= d_d;
      v2_q  <= v2_d;
    end
  end

  dark_win_min #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_dark_win_min (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v2_q),
    .in_d      (d_q),
    .out_valid (v3),
    .out_dark  (dark)
  );

  // t = 1 - (dark * omega) >> 8, optionally floored at T0
  always_comb begin
    tv_d     = v3;
    trans_d  = trans_q;
    omg_prod = OMG_PROD_W'(dark) * OMG_PROD_W'(OMEGA_Q);
    omg_term = Q_W'(omg_prod >> FRAC_SH);
    t_raw    = ONE_Q - omg_term;
    if (v3) begin
`ifdef TRANS_T0_CLAMP_EN
      trans_d = (t_raw < Q_W'(T0_Q)) ? Q_W'(T0_Q) : t_raw;
`else
      trans_d = t_raw;
`endif
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      trans_q <= '0;
      tv_q    <= 1'b0;
    end else begin
      trans_q <= trans_d;
      tv_q    <= tv_d;
    end
  end

  assign bus.transmission = trans_q;
  assign bus.trans_valid  = tv_q;

endmodule

// File: tb/tb_trans_est_top.sv
// Directed bench for trans_est_top on a 16x8 frame. Inputs change on the
// falling edge; each step first samples the outputs, then drives new inputs,
// so the result for a pixel driven at step j is observed at step j+4.
module tb_trans_est_top;

  localparam int unsigned W = 16;
  localparam int unsigned H = 8;
  localparam logic [16:0] ONE = 17'd65536;
`ifdef TRANS_T0_CLAMP_EN
  localparam logic [16:0] WHITE_T = 17'd6554;
`else
  localparam logic [16:0] WHITE_T = 17'd4097;
`endif
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  trans_est_if bus ();

  trans_est_top #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Sample outputs at the falling edge, then drive the next inputs
  task automatic step(input logic [23:0] pix, input logic vld, input logic r,
                      output logic ov, output logic [16:0] ot);
    @(negedge clk);
    ov = bus.trans_valid;
    ot = bus.transmission;
    bus.input_pixel    = pix;
    bus.input_is_valid = vld;
    rst                = r;
  endtask

  task automatic do_reset();
    logic        ov;
    logic [16:0] ot;
    step(BLACK, 1'b0, 1'b0, ov, ot);
    step(BLACK, 1'b0, 1'b0, ov, ot);
  endtask

  task automatic test_reset();
    logic        ov;
    logic [16:0] ot;
    // Reset from power-up with valid held high
    for (int i = 0; i < 3; i++) begin
      step(BLACK, 1'b1, 1'b0, ov, ot);
      vec_cnt++;
      if (ov !== 1'b0 || ot !== 17'd0) begin
        err_cnt++;
        $display("FAIL reset_hold[%0d]: got v=%0b t=%0d want v=0 t=0", i, ov, ot);
      end
    end
    // Stream black pixels past the first row, then reset mid-frame
    for (int i = 0; i < 18; i++) step(BLACK, 1'b1, 1'b1, ov, ot);
    for (int i = 0; i < 3; i++) step(BLACK, 1'b1, 1'b0, ov, ot);
    // Release with a white pixel: must be (0,0), so no black in its window
    step(WHITE, 1'b1, 1'b1, ov, ot);
    vec_cnt++;
    if (ov !== 1'b0 || ot !== 17'd0) begin
      err_cnt++;
      $display("FAIL reset_mid: got v=%0b t=%0d want v=0 t=0", ov, ot);
    end
    for (int i = 1; i <= 4; i++) begin
      step(BLACK, 1'b0, 1'b1, ov, ot);
      vec_cnt++;
      if (ov !== (i == 4)) begin
        err_cnt++;
        $display("FAIL reset_release_valid[%0d]: got %0b want %0b", i, ov, (i == 4));
      end
      if (i == 4) begin
        vec_cnt++;
        if (ot !== WHITE_T) begin
          err_cnt++;
          $display("FAIL reset_first_pixel: got %0d want %0d", ot, WHITE_T);
        end
      end
    end
  endtask

  task automatic test_single_pixel();
    logic        ov;
    logic [16:0] ot;
    do_reset();
    // R=128 G=200 B=64 -> d=16448, omega term 15420
    step(24'h80C840, 1'b1, 1'b1, ov, ot);
    for (int i = 1; i <= 4; i++) begin
      step(BLACK, 1'b0, 1'b1, ov, ot);
      vec_cnt++;
      if (ov !== (i == 4)) begin
        err_cnt++;
        $display("FAIL single_latency[%0d]: valid got %0b want %0b", i, ov, (i == 4));
      end
    end
    vec_cnt++;
    if (ot !== 17'd50116) begin
      err_cnt++;
      $display("FAIL single_value: got %0d want 50116", ot);
    end
  endtask

  task automatic test_black_white();
    logic        ov;
    logic [16:0] ot;
    logic [23:0] pix [4] = '{BLACK, WHITE, WHITE, WHITE};
    logic [16:0] exp [4] = '{ONE, ONE, ONE, WHITE_T};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step((i < 4) ? pix[i] : BLACK, i < 4, 1'b1, ov, ot);
      if (i >= 4) begin
        vec_cnt++;
        if (ov !== 1'b1 || ot !== exp[i-4]) begin
          err_cnt++;
          $display("FAIL black_white[%0d]: got v=%0b t=%0d want v=1 t=%0d", i - 4, ov, ot, exp[i-4]);
        end
      end
    end
  endtask

  task automatic test_white_row();
    logic        ov;
    logic [16:0] ot;
    do_reset();
    // One full row plus the first pixel of the next row, all white
    for (int i = 0; i < W + 1 + 4; i++) begin
      step(WHITE, i < W + 1, 1'b1, ov, ot);
      if (i >= 4) begin
        vec_cnt++;
        if (ov !== 1'b1 || ot !== WHITE_T) begin
          err_cnt++;
          $display("FAIL white_row[%0d]: got v=%0b t=%0d want v=1 t=%0d", i - 4, ov, ot, WHITE_T);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic        ov;
    logic [16:0] ot;
    // Gap cycles carry a black pixel that must not be taken
    logic [23:0] pix [6] = '{BLACK, BLACK, WHITE, WHITE, BLACK, WHITE};
    logic        vld [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [16:0] exp [6] = '{ONE, ONE, ONE, ONE, ONE, WHITE_T};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step((i < 6) ? pix[i] : BLACK, (i < 6) ? vld[i] : 1'b0, 1'b1, ov, ot);
      if (i >= 4) begin
        vec_cnt++;
        if (ov !== vld[i-4]) begin
          err_cnt++;
          $display("FAIL gaps_valid[%0d]: got %0b want %0b", i - 4, ov, vld[i-4]);
        end
        if (vld[i-4]) begin
          vec_cnt++;
          if (ot !== exp[i-4]) begin
            err_cnt++;
            $display("FAIL gaps_value[%0d]: got %0d want %0d", i - 4, ot, exp[i-4]);
          end
        end
      end
    end
  endtask

  task automatic test_black_frame();
    logic        ov;
    logic [16:0] ot;
    int          n;
    int          r;
    int          c;
    logic [16:0] e;
    n = W * H + W;
    do_reset();
    // White frame with one black pixel at (5,10), then a white row of the next frame
    for (int i = 0; i < n + 4; i++) begin
      step((i == 5 * W + 10) ? BLACK : WHITE, i < n, 1'b1, ov, ot);
      if (i >= 4) begin
        r = ((i - 4) / W) % H;
        c = (i - 4) % W;
        e = ((i - 4) < W * H && r >= 5 && r <= 7 && c >= 10 && c <= 12) ? ONE : WHITE_T;
        vec_cnt++;
        if (ov !== 1'b1 || ot !== e) begin
          err_cnt++;
          $display("FAIL black_frame[%0d] (r%0d,c%0d): got v=%0b t=%0d want v=1 t=%0d",
                   i - 4, r, c, ov, ot, e);
        end
      end
    end
  endtask

  initial begin
    rst                = 1'b0;
    bus.input_pixel    = BLACK;
    bus.input_is_valid = 1'b1;
    test_reset();
    test_single_pixel();
    test_black_white();
    test_white_row();
    test_gaps();
    test_black_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
